// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, master ids
// and default bus widths.
package dmem_arb_pkg;

    localparam int AW_DEF = 19;
    localparam int DW_DEF = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam logic M_CORE = 1'b0;
    localparam logic M_LOAD = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and Data_Memory.
// The slave view belongs to the arbiter; the master view to everything around it.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          m0_req;
    logic          m0_we;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic          core_stall;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd,
        output core_stall
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd,
        input  core_stall
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing Data_Memory between the core (m0) and the
// loader/DMA port (m1), with a bounded lock for atomic access sequences.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);

    localparam logic [7:0] MAX_L = 8'(MAX_LOCK);

    state_e        r_state;
    logic          r_rr_last;
    logic [7:0]    r_lock_cnt;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_gnt_id;
    logic          w_gnt_lock;
    logic [7:0]    w_cnt_inc;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wd;

    // Same-cycle grant: lock owner only, otherwise round-robin on contention.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (bus.m0_req && bus.m1_req) begin
                        if (r_rr_last == M_LOAD) w_gnt0 = 1'b1;
                        else                     w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = bus.m0_req;
                        w_gnt1 = bus.m1_req;
                    end
                end
                LOCK0:   w_gnt0 = bus.m0_req;
                LOCK1:   w_gnt1 = bus.m1_req;
                default: ;
            endcase
        end
    end

    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign w_gnt_id   = w_gnt1 ? M_LOAD : M_CORE;
    assign w_gnt_lock = w_gnt1 ? bus.m1_lock : bus.m0_lock;
    // Count of grants in the locked run including the current cycle.
    assign w_cnt_inc  = r_lock_cnt + 8'd1;

    // Route the granted master onto the memory port; idle bus is all zeros.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_wd   = '0;
        if (w_gnt0) begin
            w_mem_we   = bus.m0_we;
            w_mem_addr = bus.m0_addr;
            w_mem_wd   = bus.m0_wdata;
        end else if (w_gnt1) begin
            w_mem_we   = bus.m1_we;
            w_mem_addr = bus.m1_addr;
            w_mem_wd   = bus.m1_wdata;
        end
    end

    // Lock FSM and round-robin pointer. The forced release fires on the edge
    // where the run reaches MAX_LOCK grants, so the owner gets exactly
    // MAX_LOCK accesses and the pointer (now the owner) hands the next
    // contention to the other master.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_last  <= M_LOAD;
            r_lock_cnt <= 8'd0;
        end else begin
            if (w_gnt_any) r_rr_last <= w_gnt_id;
            case (r_state)
                IDLE: begin
                    if (w_gnt_any && w_gnt_lock && (8'd1 < MAX_L)) begin
                        r_state    <= w_gnt1 ? LOCK1 : LOCK0;
                        r_lock_cnt <= 8'd1;
                    end
                end
                LOCK0: begin
                    if (bus.m0_req && bus.m0_lock && (w_cnt_inc < MAX_L)) begin
                        r_lock_cnt <= w_cnt_inc;
                    end else begin
                        r_state    <= IDLE;
                        r_lock_cnt <= 8'd0;
                    end
                end
                LOCK1: begin
                    if (bus.m1_req && bus.m1_lock && (w_cnt_inc < MAX_L)) begin
                        r_lock_cnt <= w_cnt_inc;
                    end else begin
                        r_state    <= IDLE;
                        r_lock_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_lock_cnt <= 8'd0;
                end
            endcase
        end
    end

    // One-cycle read return; rdata only updates on a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.m0_we;
            r_rvalid1 <= w_gnt1 & ~bus.m1_we;
            if (w_gnt0 && !bus.m0_we) r_rdata0 <= bus.mem_rd;
            if (w_gnt1 && !bus.m1_we) r_rdata1 <= bus.mem_rd;
        end
    end

    assign bus.m0_gnt     = w_gnt0;
    assign bus.m1_gnt     = w_gnt1;
    assign bus.m0_rvalid  = r_rvalid0;
    assign bus.m1_rvalid  = r_rvalid1;
    assign bus.m0_rdata   = r_rdata0;
    assign bus.m1_rdata   = r_rdata1;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wd     = w_mem_wd;
    assign bus.core_stall = bus.m0_req & ~w_gnt0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-data scoreboard and a
// behavioural memory on the arbiter's memory port.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arb_if #(.AW(19), .DW(19)) bus ();

    dmem_arbiter #(.AW(19), .DW(19), .MAX_LOCK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: bench preload port takes priority over arbiter writes.
    logic [18:0] mem [0:255];
    logic        pl_we;
    logic [7:0]  pl_a;
    logic [18:0] pl_d;

    // Memory write port.
    always @(posedge clk) begin
        if (pl_we)            mem[pl_a] <= pl_d;
        else if (bus.mem_we)  mem[bus.mem_addr[7:0]] <= bus.mem_wd;
    end

    assign bus.mem_rd = mem[bus.mem_addr[7:0]];

    // Bench-side reference contents, updated only from the bench's own stimulus.
    logic [18:0] refm [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [18:0] q0[$];
    logic [18:0] q1[$];
    logic        pend0, pend1;
    logic [18:0] last0, last1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, l0, input logic [18:0] a0, d0,
                         input logic r1, w1, l1, input logic [18:0] a1, d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0;
        bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1;
        bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic check_ret(input string tag);
        logic [18:0] e;
        chk({tag, ":rvalid0"}, 32'(bus.m0_rvalid), 32'(pend0));
        if (pend0) begin
            e = q0.pop_front();
            last0 = e;
        end
        chk({tag, ":rdata0"}, 32'(bus.m0_rdata), 32'(last0));
        chk({tag, ":rvalid1"}, 32'(bus.m1_rvalid), 32'(pend1));
        if (pend1) begin
            e = q1.pop_front();
            last1 = e;
        end
        chk({tag, ":rdata1"}, 32'(bus.m1_rdata), 32'(last1));
    endtask

    // One clock cycle of stimulus with the expected grant pair.
    task automatic step(input string tag,
                        input logic r0, w0, l0, input logic [18:0] a0, d0,
                        input logic r1, w1, l1, input logic [18:0] a1, d1,
                        input logic e0, e1);
        logic        ewe;
        logic [18:0] ea, ed;
        @(negedge clk);
        drive(r0, w0, l0, a0, d0, r1, w1, l1, a1, d1);
        #1;
        chk({tag, ":gnt0"}, 32'(bus.m0_gnt), 32'(e0));
        chk({tag, ":gnt1"}, 32'(bus.m1_gnt), 32'(e1));
        chk({tag, ":stall"}, 32'(bus.core_stall), 32'(r0 & ~e0));
        ewe = 1'b0; ea = '0; ed = '0;
        if (e0)      begin ewe = w0; ea = a0; ed = d0; end
        else if (e1) begin ewe = w1; ea = a1; ed = d1; end
        chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'(ewe));
        chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'(ea));
        chk({tag, ":mem_wd"}, 32'(bus.mem_wd), 32'(ed));
        check_ret(tag);
        pend0 = e0 & ~w0;
        pend1 = e1 & ~w1;
        if (pend0) q0.push_back(refm[a0[7:0]]);
        if (pend1) q1.push_back(refm[a1[7:0]]);
        if (e0 && w0) refm[a0[7:0]] = d0;
        if (e1 && w1) refm[a1[7:0]] = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        last0 = '0; last1 = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Preload memory while the arbiter is held in reset.
        @(negedge clk); pl_we = 1'b1; pl_a = 8'h10; pl_d = 19'h1ABCD; refm[8'h10] = 19'h1ABCD;
        @(negedge clk); pl_a = 8'h11; pl_d = 19'h12345; refm[8'h11] = 19'h12345;
        @(negedge clk); pl_a = 8'h05; pl_d = 19'h05A5A; refm[8'h05] = 19'h05A5A;
        @(negedge clk); pl_we = 1'b0;

        // Requests are ignored and the bus is quiet while reset is high.
        drive(1, 0, 0, 19'h00010, 0, 1, 1, 0, 19'h00011, 19'h00111);
        #1;
        chk("rst:gnt0", 32'(bus.m0_gnt), 32'd0);
        chk("rst:gnt1", 32'(bus.m1_gnt), 32'd0);
        chk("rst:mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst:mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst:mem_wd", 32'(bus.mem_wd), 32'd0);
        check_ret("rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;

        // Single read from the core.
        step("rd0",   1, 0, 0, 19'h00010, 0,  0, 0, 0, 0, 0,  1, 0);
        step("idle1", 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,  0, 0);

        // Loader alone, then four contended cycles alternate m0,m1,m0,m1.
        step("m1solo", 0, 0, 0, 0, 0,          1, 0, 0, 19'h00011, 0,  0, 1);
        step("alt1",   1, 0, 0, 19'h00010, 0,  1, 0, 0, 19'h00011, 0,  1, 0);
        step("alt2",   1, 0, 0, 19'h00010, 0,  1, 0, 0, 19'h00011, 0,  0, 1);
        step("alt3",   1, 0, 0, 19'h00010, 0,  1, 0, 0, 19'h00011, 0,  1, 0);
        step("alt4",   1, 0, 0, 19'h00010, 0,  1, 0, 0, 19'h00011, 0,  0, 1);

        // Locked three-write sequence by the loader while the core waits.
        step("m0pre", 1, 0, 0, 19'h00010, 0,  0, 0, 0, 0, 0,                   1, 0);
        step("lk1",   1, 0, 0, 19'h00010, 0,  1, 1, 1, 19'h00020, 19'h7FFFF,  0, 1);
        step("lk2",   1, 0, 0, 19'h00010, 0,  1, 1, 1, 19'h00020, 19'h7FFFF,  0, 1);
        step("lk3",   1, 0, 0, 19'h00010, 0,  1, 1, 0, 19'h00020, 19'h7FFFF,  0, 1);
        step("lk4",   1, 0, 0, 19'h00020, 0,  0, 0, 0, 0, 0,                   1, 0);
        step("lk5",   0, 0, 0, 0, 0,          0, 0, 0, 0, 0,                   0, 0);

        // Loader holds lock forever: forced release after 8 grants.
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("max%0d", i),
                 1, 0, 0, 19'h00010, 0,
                 1, 1, 1, 19'(32'h30 + i), 19'(i),
                 (i == 9), (i < 9));
        end

        // Reset during the second cycle of a locked loader read sequence.
        step("rstA", 1, 0, 0, 19'h00010, 0,  1, 0, 1, 19'h00011, 0,  0, 1);
        step("rstB", 1, 0, 0, 19'h00010, 0,  1, 0, 1, 19'h00011, 0,  0, 1);
        rst = 1'b1;
        #1;
        chk("rstB:rst_gnt0", 32'(bus.m0_gnt), 32'd0);
        chk("rstB:rst_gnt1", 32'(bus.m1_gnt), 32'd0);
        chk("rstB:rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstB:rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstB:rst_rvalid1", 32'(bus.m1_rvalid), 32'd0);
        q0.delete(); q1.delete();
        pend0 = 1'b0; pend1 = 1'b0;
        last0 = '0; last1 = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step("post", 1, 0, 0, 19'h00010, 0,  1, 0, 0, 19'h00011, 0,  1, 0);

        // Core read, then a loader write must not raise rvalid; rdata holds.
        step("rd5",  1, 0, 0, 19'h00005, 0,  0, 0, 0, 0, 0,                   1, 0);
        step("wr1",  0, 0, 0, 0, 0,          1, 1, 0, 19'h00040, 19'h00777,  0, 1);
        step("hold", 0, 0, 0, 0, 0,          0, 0, 0, 0, 0,                   0, 0);
        step("hold2",0, 0, 0, 0, 0,          0, 0, 0, 0, 0,                   0, 0);
        chk("hold2:rdata0_const", 32'(bus.m0_rdata), 32'h05A5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 19-bit data memory between two requesters:
  - m0: the processor core load/store port.
  - m1: the program loader / DMA port.
- Round-robin arbitration with an optional bounded lock for atomic multi-access sequences.
- Sits between the requesters and Data_Memory. Drives core_stall back to the PC/control path when the core loses arbitration.

Parameters:
- AW, 19, address width.
- DW, 19, data width.
- MAX_LOCK, 8, maximum consecutive cycles a locked owner may hold the memory before forced release (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  core requests access this cycle.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  request to keep ownership after this access.
- m0_addr  in  AW  access address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle (combinational).
- m0_rvalid  out  1  read data valid (registered).
- m0_rdata  out  DW  read data (registered).
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational read).
- core_stall  out  1  equals m0_req & ~m0_gnt.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_last=1 (m0 favoured next), lock_cnt=0.
  - m0/m1_rvalid=0, m0/m1_rdata=0.
  - All gnt=0, mem_we=0, mem_addr=0, mem_wd=0 while rst is high.
- Grant (combinational, same cycle as req):
  - IDLE, one requester: grant it.
  - IDLE, both requesting: grant the one not equal to rr_last.
  - LOCK0: only m0 may be granted; m1_gnt=0.
  - LOCK1: only m1 may be granted; m0_gnt=0.
  - At most one gnt high per cycle.
- Memory drive: mem_addr/mem_wd/mem_we come from the granted master; mem_we = granted & we. With no grant: mem_we=0, addr/wd=0.
- Pointer: on each clock edge with a grant, rr_last <= granted id.
- Read latency 1: granted read in cycle N gives mx_rvalid=1 and mx_rdata=mem_rd (sampled at N's edge) in cycle N+1. A write produces no rvalid. rdata holds its value when rvalid=0.
- Lock FSM states: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCKx when x is granted with x_lock=1; lock_cnt <= 1.
  - LOCKx -> LOCKx while x_req & x_lock & lock_cnt<MAX_LOCK; lock_cnt increments on each cycle x is granted.
  - LOCKx -> IDLE when x_lock=0, or x_req=0, or lock_cnt==MAX_LOCK (forced release). On forced release rr_last <= x, so the other master wins the next contention.
  - While LOCKx, the owner's access in the releasing cycle is still granted.
- Simultaneous lock requests in IDLE: only the granted master's lock is honoured.
- Reset mid-lock: state returns to IDLE immediately. An in-flight rvalid is dropped.
- No address decoding or range checks. Every address is forwarded unchanged.

Decomposition:
- Package dmem_arb_pkg holds:
  - State encoding: IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2.
  - Master ids: M_CORE=1'b0, M_LOAD=1'b1.
  - Defaults for AW and DW.
- Flat module; no sub-module needed. Grant logic, FSM, pointer and read-return registers total about 150–200 lines.

Test Plan:
- Reset, then m0 reads addr 0x00010 while the memory holds 0x1ABCD -> m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0x1ABCD; core_stall=0.
- m0 and m1 both request for 4 cycles, no lock -> grants alternate m0,m1,m0,m1; core_stall=1 exactly in the m1 cycles.
- m1 writes 0x7FFFF to addr 0x00020 with lock=1 for 3 cycles while m0 requests -> m1 granted 3 cycles; mem_we=1 each; m0 granted in cycle 4.
- m1 holds lock=1 and req=1 indefinitely, MAX_LOCK=8, m0 requesting -> m1 granted 8 cycles; FSM returns to IDLE; m0 granted on the 9th cycle.
- rst asserted in the 2nd cycle of a LOCK1 sequence with a read in flight -> next cycle all rvalid=0, state IDLE, m0 wins the first contention after reset.
- m0 reads 0x00005 while m1 idle, then m1 alone writes -> no spurious rvalid on the write; m0_rdata holds its last value.
